// File: rtl/d_pipe_skid_if.sv
// d_pipe_skid_if: valid/ready/data handshake bundle for one end of the pipeline
interface d_pipe_skid_if #(parameter int WIDTH = 8);
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, data, input ready);
  modport slave (input valid, data, output ready);
endinterface

// File: rtl/d_pipe_skid.sv
// d_pipe_skid: DEPTH-stage valid/ready pipeline of two-entry skid slices
module d_pipe_skid #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(2*DEPTH+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  d_pipe_skid_if.slave up,
  d_pipe_skid_if.master dn,
  output logic [CW-1:0] count
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} st_t;
  logic [DEPTH:0] vld, rdy;
  logic [WIDTH-1:0] dat [DEPTH+1];
  assign vld[0] = up.valid & !flush;
  assign up.ready = rdy[0] & !flush;
  assign dat[0] = up.data;
  assign rdy[DEPTH] = dn.ready;
  assign dn.valid = vld[DEPTH];
  assign dn.data = dat[DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    st_t st_q, st_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic acc, go, ld_main, ld_skid;
    assign acc = vld[k] & rdy[k];
    assign go = rdy[k+1];
    assign rdy[k] = st_q != FULL;
    assign vld[k+1] = (st_q != EMPTY) & ((k < DEPTH-1) | !flush);
    assign dat[k+1] = main_q;
    // next state and register load enables of this slice
    always_comb begin
      st_d = st_q == EMPTY ? (acc ? BUSY : EMPTY) :
             st_q == BUSY  ? (acc & !go ? FULL : !acc & go ? EMPTY : BUSY) :
             (go ? BUSY : FULL);
      ld_main = st_q == FULL ? go : acc & (st_q == EMPTY | go);
      ld_skid = (st_q == BUSY) & acc & !go;
    end
    // slice state and data registers; flush empties the slice but keeps data
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q <= EMPTY;
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
      end else if (flush) begin
        st_q <= EMPTY;
      end else begin
        st_q <= st_d;
        if (ld_main) main_q <= st_q == FULL ? skid_q : dat[k];
        if (ld_skid) skid_q <= dat[k];
      end
    end
  end
  // occupancy tracks end-to-end transfers
  always_ff @(posedge clk) begin
    if (!rst_n || flush) count <= '0;
    else count <= count + CW'(up.valid & up.ready) - CW'(dn.valid & dn.ready);
  end
endmodule

// File: tb/tb_d_pipe_skid.sv
// tb_d_pipe_skid: scoreboard bench for the skid pipeline
module tb_d_pipe_skid;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;
  int n_out = 0;
  logic chk_en = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  d_pipe_skid_if #(.WIDTH(8)) up_if();
  d_pipe_skid_if #(.WIDTH(8)) dn_if();
  d_pipe_skid #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up_if), .dn(dn_if), .count(count)
  );
  always #5 clk = ~clk;
  // scoreboard: sample mid-cycle, pop on output transfer, push on input transfer
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      checks++;
      if (count !== 3'(q.size())) begin
        failures++;
        $display("FAIL count_track got=%0d exp=%0d", count, q.size());
      end
    end
    if (!rst_n || flush) q.delete();
    else begin
      if (dn_if.valid && dn_if.ready) begin
        checks++;
        n_out++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out got=%h exp=none", dn_if.data);
        end else begin
          exp_d = q.pop_front();
          if (dn_if.data !== exp_d) begin
            failures++;
            $display("FAIL out_data got=%h exp=%h", dn_if.data, exp_d);
          end
        end
      end
      if (up_if.valid && up_if.ready) q.push_back(up_if.data);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    up_if.valid = 1;
    up_if.data = 8'h11;
    dn_if.ready = 1;
    tick;
    tick;
    rst_n = 1;
    up_if.valid = 0;
    #1;
    checks += 4;
    if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", dn_if.valid); end
    if (up_if.ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", up_if.ready); end
    if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (dn_if.data !== 8'hA5) begin failures++; $display("FAIL reset_out_data got=%h exp=a5", dn_if.data); end
    chk_en = 1;
    repeat (4) tick;
    checks++;
    if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL reset_no_output got=%b exp=0", dn_if.valid); end
  endtask
  task automatic test_stream;
    int n0;
    n0 = n_out;
    dn_if.ready = 1;
    for (int j = 0; j < 20; j++) begin
      up_if.valid = j < 16;
      up_if.data = 8'(j + 1);
      #1;
      if (j < 16) begin
        checks++;
        if (up_if.ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", j, up_if.ready); end
      end
      if (j < 3) begin
        checks++;
        if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid cyc=%0d got=%b exp=0", j, dn_if.valid); end
      end
      if (j == 3) begin
        checks++;
        if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h01) begin
          failures++;
          $display("FAIL stream_latency got=%b/%h exp=1/01", dn_if.valid, dn_if.data);
        end
      end
      if (j == 8) begin
        checks++;
        if (count !== 3'd3) begin failures++; $display("FAIL stream_steady_count got=%0d exp=3", count); end
      end
      tick;
    end
    checks += 2;
    if (n_out - n0 != 16) begin failures++; $display("FAIL stream_words got=%0d exp=16", n_out - n0); end
    if (count !== 3'd0) begin failures++; $display("FAIL stream_drain_count got=%0d exp=0", count); end
  endtask
  task automatic test_backpressure;
    int acc;
    int n0;
    logic a;
    acc = 0;
    dn_if.ready = 0;
    up_if.valid = 1;
    up_if.data = 8'h20;
    for (int j = 0; j < 10; j++) begin
      #1;
      a = up_if.ready;
      tick;
      if (a) begin
        acc++;
        up_if.data = up_if.data + 8'd1;
      end
    end
    checks += 4;
    if (acc != 6) begin failures++; $display("FAIL bp_accepted got=%0d exp=6", acc); end
    if (up_if.ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", up_if.ready); end
    if (count !== 3'd6) begin failures++; $display("FAIL bp_count got=%0d exp=6", count); end
    if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h20) begin
      failures++;
      $display("FAIL bp_out_held got=%b/%h exp=1/20", dn_if.valid, dn_if.data);
    end
    up_if.valid = 0;
    dn_if.ready = 1;
    n0 = n_out;
    repeat (8) tick;
    checks += 2;
    if (n_out - n0 != 6) begin failures++; $display("FAIL bp_drain_words got=%0d exp=6", n_out - n0); end
    if (count !== 3'd0) begin failures++; $display("FAIL bp_drain_count got=%0d exp=0", count); end
  endtask
  task automatic test_random;
    int n_in;
    int n0;
    logic a;
    n_in = 0;
    n0 = n_out;
    for (int j = 0; j < 20000 && n_in < 1000; j++) begin
      up_if.valid = 1'($urandom_range(0, 1));
      up_if.data = 8'($urandom);
      dn_if.ready = 1'($urandom_range(0, 1));
      #1;
      a = up_if.valid & up_if.ready;
      tick;
      if (a) n_in++;
    end
    up_if.valid = 0;
    dn_if.ready = 1;
    repeat (10) tick;
    checks += 3;
    if (n_in != 1000) begin failures++; $display("FAIL rand_sent got=%0d exp=1000", n_in); end
    if (n_out - n0 != 1000) begin failures++; $display("FAIL rand_received got=%0d exp=1000", n_out - n0); end
    if (count !== 3'd0) begin failures++; $display("FAIL rand_drain_count got=%0d exp=0", count); end
  endtask
  task automatic test_flush;
    int n0;
    dn_if.ready = 0;
    up_if.valid = 1;
    for (int j = 0; j < 4; j++) begin
      up_if.data = 8'(8'h40 + j);
      tick;
    end
    checks++;
    if (count !== 3'd4) begin failures++; $display("FAIL flush_pre_count got=%0d exp=4", count); end
    flush = 1;
    up_if.data = 8'hEE;
    dn_if.ready = 1;
    #1;
    checks += 2;
    if (up_if.ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", up_if.ready); end
    if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", dn_if.valid); end
    tick;
    flush = 0;
    up_if.valid = 0;
    #1;
    checks += 3;
    if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL flush_after_valid got=%b exp=0", dn_if.valid); end
    if (up_if.ready !== 1'b1) begin failures++; $display("FAIL flush_after_ready got=%b exp=1", up_if.ready); end
    n0 = n_out;
    up_if.valid = 1;
    for (int j = 0; j < 2; j++) begin
      up_if.data = 8'(8'h50 + j);
      tick;
    end
    up_if.valid = 0;
    repeat (6) tick;
    checks++;
    if (n_out - n0 != 2) begin failures++; $display("FAIL flush_restart_words got=%0d exp=2", n_out - n0); end
  endtask
  task automatic test_reset_mid;
    int n0;
    dn_if.ready = 0;
    up_if.valid = 1;
    for (int j = 0; j < 5; j++) begin
      up_if.data = 8'(8'h60 + j);
      tick;
    end
    checks++;
    if (count !== 3'd5) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=5", count); end
    rst_n = 0;
    up_if.valid = 0;
    tick;
    rst_n = 1;
    #1;
    checks += 4;
    if (count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", dn_if.valid); end
    if (dn_if.data !== 8'hA5) begin failures++; $display("FAIL rstmid_out_data got=%h exp=a5", dn_if.data); end
    if (up_if.ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", up_if.ready); end
    n0 = n_out;
    dn_if.ready = 1;
    up_if.valid = 1;
    for (int j = 0; j < 4; j++) begin
      up_if.data = 8'(8'h70 + j);
      tick;
    end
    up_if.valid = 0;
    repeat (6) tick;
    checks += 2;
    if (n_out - n0 != 4) begin failures++; $display("FAIL rstmid_restart_words got=%0d exp=4", n_out - n0); end
    if (count !== 3'd0) begin failures++; $display("FAIL rstmid_restart_count got=%0d exp=0", count); end
  endtask
  initial begin
    up_if.valid = 0;
    up_if.data = '0;
    dn_if.ready = 0;
    test_reset;
    test_stream;
    test_backpressure;
    test_random;
    test_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
